// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: per-sample resize modes and
// width helpers used to size intermediate arithmetic.
package fir_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_RND_SAT = 2'd2,
        MODE_USAT    = 2'd3
    } mode_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Intermediate width: two guard bits cover the rounding carry and keep
    // zero-extended unsigned samples positive under signed arithmetic.
    function automatic int unsigned resize_width(input int unsigned in_w, input int unsigned out_w);
        return max_u(in_w, out_w) + 2;
    endfunction

endpackage

// File: rtl/sat_clip.sv
// Combinational range check of a signed IN_W-bit value against an OUT_W-bit
// target, with wrap / signed saturate / unsigned saturate selection.
// Ports:
//   din    in   IN_W   value to resize (two's complement)
//   mode   in   2      resize mode (fir_pkg::mode_e)
//   dout_c out  OUT_W  resized value
//   ovf_c  out  1      value was outside the target range (wrapped or clipped)
module sat_clip
    import fir_pkg::*;
#(
    parameter int unsigned IN_W  = 34,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  din,
    input  mode_e            mode,
    output logic [OUT_W-1:0] dout_c,
    output logic             ovf_c
);

    if (IN_W < OUT_W + 2) begin : g_bad_width
        $error("sat_clip: IN_W must be at least OUT_W+2");
    end

    localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed_fit_c;
    logic unsigned_fit_c;

    // Signed fit: all bits from the target sign bit upward agree.
    // Unsigned fit: nothing set above the target width (sign included).
    always_comb begin
        signed_fit_c   = (&din[IN_W-1:OUT_W-1]) | ~(|din[IN_W-1:OUT_W-1]);
        unsigned_fit_c = ~(|din[IN_W-1:OUT_W]);
    end

    // Select output and flag overflow.
    always_comb begin
        dout_c = din[OUT_W-1:0];
        ovf_c  = 1'b0;
        case (mode)
            MODE_WRAP: begin
                ovf_c = ~signed_fit_c;
            end
            MODE_SAT, MODE_RND_SAT: begin
                if (!signed_fit_c) begin
                    ovf_c  = 1'b1;
                    dout_c = din[IN_W-1] ? SMIN : SMAX;
                end
            end
            MODE_USAT: begin
                if (!unsigned_fit_c) begin
                    ovf_c  = 1'b1;
                    dout_c = '1;
                end
            end
            default: begin
                ovf_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sample_resize.sv
// Two-stage pipelined signed sample width converter with valid/ready
// handshaking. Stage 1 extends, optionally rounds and shifts; stage 2
// range-checks and wraps or clips. Overflow statistics are kept per sample.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_data/in_mode/in_valid input sample, per-sample mode, valid
//   in_ready                 sample accepted this cycle (combinational from out_ready)
//   out_data/out_valid       resized sample and valid
//   out_ready                downstream accepts
//   ovf_sticky, clip_count   overflow flag and saturating overflow counter
//   clr_stats                synchronous clear of the statistics
module sample_resize
    import fir_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 5,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned SHIFT     = 0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [1:0]           in_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovf_sticky,
    output logic [CNT_WIDTH-1:0] clip_count,
    input  logic                 clr_stats
);

    localparam int unsigned W = resize_width(IN_WIDTH, OUT_WIDTH);

    // Half-LSB of the shifted result; zero when there is no shift.
    localparam logic [W-1:0] RND_INC =
        (SHIFT > 0) ? (W'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : W'(0);

    if (SHIFT >= IN_WIDTH || IN_WIDTH < 2 || OUT_WIDTH < 2) begin : g_illegal_param
        $error("sample_resize: requires SHIFT < IN_WIDTH and widths >= 2");
    end

    logic [W-1:0]         ext_c;
    logic [W-1:0]         sum_c;
    logic [W-1:0]         shr_c;
    logic                 s2_load_c;
    logic                 event_c;
    logic [OUT_WIDTH-1:0] clip_c;
    logic                 ovf_c;

    logic                 s1_valid;
    logic [W-1:0]         s1_data;
    mode_e                s1_mode;
    logic                 s2_valid;

    // Stage 1 arithmetic: extend, optional round-half-up, arithmetic shift.
    always_comb begin
        if (mode_e'(in_mode) == MODE_USAT) begin
            ext_c = W'(in_data);
        end else begin
            ext_c = W'($signed(in_data));
        end
        sum_c = ext_c;
        if (mode_e'(in_mode) == MODE_RND_SAT) begin
            sum_c = ext_c + RND_INC;
        end
        shr_c = W'($signed(sum_c) >>> SHIFT);
    end

    sat_clip #(
        .IN_W  (W),
        .OUT_W (OUT_WIDTH)
    ) u_sat_clip (
        .din    (s1_data),
        .mode   (s1_mode),
        .dout_c (clip_c),
        .ovf_c  (ovf_c)
    );

    // Handshake: stage 2 refills when empty or draining; stage 1 follows it.
    always_comb begin
        s2_load_c = ~s2_valid | out_ready;
        in_ready  = ~s1_valid | s2_load_c;
        event_c   = s2_load_c & s1_valid & ovf_c;
    end

    assign out_valid = s2_valid;

    // Pipeline registers and statistics; an overflow is counted on the single
    // cycle its sample moves into stage 2, so stalls cannot double count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_mode    <= MODE_WRAP;
            s2_valid   <= 1'b0;
            out_data   <= '0;
            ovf_sticky <= 1'b0;
            clip_count <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= shr_c;
                    s1_mode <= mode_e'(in_mode);
                end
            end
            if (s2_load_c) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= clip_c;
                end
            end
            if (clr_stats) begin
                ovf_sticky <= 1'b0;
                clip_count <= '0;
            end else if (event_c) begin
                ovf_sticky <= 1'b1;
                if (clip_count != {CNT_WIDTH{1'b1}}) begin
                    clip_count <= clip_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_resize.sv
// Scoreboard bench for sample_resize: a widening instance (5->32), a
// narrowing instance (16->8, shift 4) and a narrow-counter instance.
module tb_sample_resize;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // ---------------- instance A: widening 5 -> 32 ----------------
    logic        rst = 1'b1;
    logic [4:0]  a_in_data = '0;
    logic [1:0]  a_in_mode = '0;
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
    logic [31:0] a_out_data;
    logic        a_ovf, a_clr = 1'b0;
    logic [15:0] a_cnt;
    logic [31:0] a_q[$];

    sample_resize #(.IN_WIDTH(5), .OUT_WIDTH(32), .SHIFT(0), .CNT_WIDTH(16)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_mode(a_in_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .ovf_sticky(a_ovf),
        .clip_count(a_cnt), .clr_stats(a_clr)
    );

    // ---------------- instance B: narrowing 16 -> 8, shift 4 ----------------
    logic        rst_b = 1'b1;
    logic [15:0] b_in_data = '0;
    logic [1:0]  b_in_mode = '0;
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic [7:0]  b_out_data;
    logic        b_ovf, b_clr = 1'b0;
    logic [15:0] b_cnt;
    logic [7:0]  b_q[$];

    sample_resize #(.IN_WIDTH(16), .OUT_WIDTH(8), .SHIFT(4), .CNT_WIDTH(16)) u_b (
        .clk(clk), .rst(rst_b), .in_data(b_in_data), .in_mode(b_in_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .ovf_sticky(b_ovf),
        .clip_count(b_cnt), .clr_stats(b_clr)
    );

    // ---------------- instance C: 2-bit clip counter ----------------
    logic [15:0] c_in_data = '0;
    logic [1:0]  c_in_mode = '0;
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1;
    logic [7:0]  c_out_data;
    logic        c_ovf, c_clr = 1'b0;
    logic [1:0]  c_cnt;

    sample_resize #(.IN_WIDTH(16), .OUT_WIDTH(8), .SHIFT(4), .CNT_WIDTH(2)) u_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_mode(c_in_mode),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .ovf_sticky(c_ovf),
        .clip_count(c_cnt), .clr_stats(c_clr)
    );

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) fail_now("a_unexpected_output");
            else chk("a_out_data", a_out_data, a_q.pop_front());
        end
    end

    logic       b_prev_stall = 1'b0;
    logic [7:0] b_prev_data  = '0;

    always @(negedge clk) begin
        if (b_prev_stall && b_out_valid) chk("b_hold_data", 32'(b_out_data), 32'(b_prev_data));
        if (b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) fail_now("b_unexpected_output");
            else chk("b_out_data", 32'(b_out_data), 32'(b_q.pop_front()));
        end
        b_prev_stall = b_out_valid && !b_out_ready;
        b_prev_data  = b_out_data;
    end

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic send_a(input logic [4:0] d, input logic [1:0] m, input logic [31:0] e);
        logic acc = 1'b0;
        a_q.push_back(e);
        a_in_data = d; a_in_mode = m; a_in_valid = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk); acc = a_in_ready;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        if (!acc) fail_now("a_send_timeout");
    endtask

    task automatic send_b(input logic [15:0] d, input logic [1:0] m, input logic [7:0] e,
                          input bit push);
        logic acc = 1'b0;
        if (push) b_q.push_back(e);
        b_in_data = d; b_in_mode = m; b_in_valid = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk); acc = b_in_ready;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        if (!acc) fail_now("b_send_timeout");
    endtask

    task automatic send_c(input logic [15:0] d, input logic [1:0] m);
        logic acc = 1'b0;
        c_in_data = d; c_in_mode = m; c_in_valid = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk); acc = c_in_ready;
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0;
        if (!acc) fail_now("c_send_timeout");
    endtask

    task automatic drain_a();
        for (int t = 0; t < 100 && a_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        if (a_q.size() != 0) fail_now("a_drain_timeout");
        @(posedge clk); #1;
    endtask

    task automatic drain_b();
        for (int t = 0; t < 200 && b_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        if (b_q.size() != 0) fail_now("b_drain_timeout");
        @(posedge clk); #1;
    endtask

    // Backpressure stream: data, mode, expected output.
    logic [15:0] st_d[10] = '{16'h0010, 16'h0FF0, 16'hF800, 16'hF7F0, 16'h0007,
                              16'h0008, 16'h07F8, 16'h07F0, 16'h0FF0, 16'h1000};
    logic [1:0]  st_m[10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [7:0]  st_e[10] = '{8'h01, 8'hFF, 8'h80, 8'h80, 8'h00,
                              8'h01, 8'h7F, 8'h7F, 8'hFF, 8'hFF};
    bit sends_done = 1'b0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst_b = 1'b0;

        // Reset state
        chk("a_rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("a_rst_out_data", a_out_data, 32'd0);
        chk("a_rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("a_rst_cnt", 32'(a_cnt), 32'd0);
        chk("b_rst_out_valid", 32'(b_out_valid), 32'd0);
        chk("b_rst_ovf", 32'(b_ovf), 32'd0);

        // Widening
        send_a(5'b00111, 2'd0, 32'h0000_0007);
        send_a(5'b10000, 2'd0, 32'hFFFF_FFF0);
        drain_a();
        chk("a_ovf_none", 32'(a_ovf), 32'd0);
        chk("a_cnt_none", 32'(a_cnt), 32'd0);

        // Narrowing, mode 2
        send_b(16'h0018, 2'd2, 8'h02, 1'b1);
        send_b(16'hFFE8, 2'd2, 8'hFF, 1'b1);
        drain_b();
        chk("b_ovf_inrange", 32'(b_ovf), 32'd0);
        chk("b_cnt_inrange", 32'(b_cnt), 32'd0);
        send_b(16'h7FFF, 2'd2, 8'h7F, 1'b1);
        drain_b();
        chk("b_ovf_posclip", 32'(b_ovf), 32'd1);
        chk("b_cnt_posclip", 32'(b_cnt), 32'd1);
        send_b(16'h8000, 2'd2, 8'h80, 1'b1);
        drain_b();
        chk("b_cnt_negclip", 32'(b_cnt), 32'd2);

        // Wrap, saturate, unsigned saturate
        send_b(16'h0800, 2'd0, 8'h80, 1'b1);
        send_b(16'h0800, 2'd1, 8'h7F, 1'b1);
        send_b(16'hFFFF, 2'd3, 8'hFF, 1'b1);
        drain_b();
        chk("b_cnt_modes", 32'(b_cnt), 32'd5);

        // Backpressure stream with out_ready pattern 1,0,0,...
        fork
            begin
                for (int i = 0; i < 10; i++) send_b(st_d[i], st_m[i], st_e[i], 1'b1);
                sends_done = 1'b1;
            end
            begin
                for (int c = 0; c < 500 && !sends_done; c++) begin
                    b_out_ready = (c % 3 == 0);
                    @(posedge clk); #1;
                end
            end
        join
        b_out_ready = 1'b1;
        drain_b();
        chk("b_cnt_stream", 32'(b_cnt), 32'd9);
        chk("b_ovf_stream", 32'(b_ovf), 32'd1);

        b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        chk("b_cnt_clr", 32'(b_cnt), 32'd0);
        chk("b_ovf_clr", 32'(b_ovf), 32'd0);

        // Reset with both stages full; the held samples are discarded
        b_out_ready = 1'b0;
        send_b(16'h7FFF, 2'd1, 8'h00, 1'b0);
        send_b(16'h0018, 2'd2, 8'h00, 1'b0);
        chk("b_full_in_ready", 32'(b_in_ready), 32'd0);
        chk("b_full_out_valid", 32'(b_out_valid), 32'd1);
        chk("b_full_cnt", 32'(b_cnt), 32'd1);
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        chk("b_mrst_out_valid", 32'(b_out_valid), 32'd0);
        chk("b_mrst_cnt", 32'(b_cnt), 32'd0);
        chk("b_mrst_ovf", 32'(b_ovf), 32'd0);
        chk("b_mrst_in_ready", 32'(b_in_ready), 32'd1);

        // Latency of the first post-reset sample
        b_out_ready = 1'b1;
        b_q.push_back(8'h02);
        b_in_data = 16'h0018; b_in_mode = 2'd2; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("b_lat_cycle1", 32'(b_out_valid), 32'd0);
        @(posedge clk); #1;
        chk("b_lat_cycle2", 32'(b_out_valid), 32'd1);
        drain_b();

        // Counter saturation on a 2-bit counter
        for (int i = 0; i < 5; i++) send_c(16'h7FFF, 2'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("c_cnt_sat", 32'(c_cnt), 32'd3);
        chk("c_ovf_set", 32'(c_ovf), 32'd1);
        chk("c_out_clip", 32'(c_out_data), 32'h7F);

        // clr_stats in the same cycle as a clip event: event is lost
        send_c(16'h7FFF, 2'd1);
        c_clr = 1'b1;
        @(posedge clk); #1;
        c_clr = 1'b0;
        chk("c_cnt_clr_event", 32'(c_cnt), 32'd0);
        chk("c_ovf_clr_event", 32'(c_ovf), 32'd0);
        @(posedge clk); #1;
        chk("c_cnt_after_clr", 32'(c_cnt), 32'd0);

        chk("a_queue_empty", 32'(a_q.size()), 32'd0);
        chk("b_queue_empty", 32'(b_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
